// File: rtl/bram_scan_sequencer_pkg.sv
// Shared widths, pipeline latencies and FSM encodings for the BRAM scan sequencer.
package bram_scan_sequencer_pkg;

    localparam int DEF_J_SIZE            = 9;
    localparam int DEF_X_SIZE            = 3;
    localparam int DEF_BRAM_NUMBER_SIZE  = 5;
    localparam int DEF_BRAM_ADDRESS_SIZE = 8;

    localparam int DEF_CALC_LATENCY = 1;
    localparam int DEF_READ_LATENCY = 1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    function automatic logic is_busy_state(input state_t s);
        return (s == S_RUN) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/bram_scan_sequencer_valid_delay_line.sv
// N-stage shift register carrying a {valid,last} beat; last is forced low on empty stages.
module valid_delay_line #(
    parameter int N = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o,
    output logic inner_o
);

    generate
        if (N == 0) begin : g_pass
            assign valid_o = valid_i;
            assign last_o  = valid_i & last_i;
            assign inner_o = 1'b0;
        end else begin : g_shift
            logic [N-1:0] valid_q;
            logic [N-1:0] last_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    valid_q <= '0;
                    last_q  <= '0;
                end else begin
                    valid_q[0] <= valid_i;
                    last_q[0]  <= valid_i & last_i;
                    for (int i = 1; i < N; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        last_q[i]  <= last_q[i-1];
                    end
                end
            end

            assign valid_o = valid_q[N-1];
            assign last_o  = last_q[N-1];

            // inner_o reports beats still in flight ahead of the output stage
            if (N == 1) begin : g_one
                assign inner_o = 1'b0;
            end else begin : g_many
                assign inner_o = |valid_q[N-2:0];
            end
        end
    endgenerate

endmodule

// File: rtl/bram_scan_sequencer.sv
// Sweeps (j, x_enc) for the BRAM address calculator and tracks beats through calc/read latency.
// Optional stall_cycles counter is built when BRAM_SCAN_STALL_CNT_EN is defined.
module bram_scan_sequencer
    import bram_scan_sequencer_pkg::*;
#(
    parameter int J_SIZE       = DEF_J_SIZE,
    parameter int X_SIZE       = DEF_X_SIZE,
    parameter int CALC_LATENCY = DEF_CALC_LATENCY,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [J_SIZE-1:0] j_last,
    input  logic [X_SIZE-1:0] x_last,
    input  logic              out_ready,
    output logic [J_SIZE-1:0] j,
    output logic [X_SIZE-1:0] x_enc,
    output logic              addr_valid,
    output logic              addr_last,
    output logic              data_valid,
    output logic              data_last,
    output logic              busy,
    output logic              done
`ifdef BRAM_SCAN_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    state_t state_q, state_d;
    logic [J_SIZE-1:0] j_q, j_d;
    logic [X_SIZE-1:0] x_q, x_d;
    logic [J_SIZE-1:0] jLast_q, jLast_d;
    logic [X_SIZE-1:0] xLast_q, xLast_d;

    logic startAccept;
    logic atFinal;
    logic issue;
    logic calcInner;
    logic readInner;
    logic drainsNext;

    assign startAccept = (state_q == S_IDLE) && start && !abort;
    assign atFinal     = (j_q == jLast_q) && (x_q == xLast_q);
    // An abort only wins over an issue that is not the final one
    assign issue       = (state_q == S_RUN) && out_ready && (!abort || atFinal);

    // DRAIN can leave once only the output stage of the read line may still hold a beat
    assign drainsNext = (READ_LATENCY == 0) ? !calcInner
                                            : (!calcInner && !addr_valid && !readInner);

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        x_d     = x_q;
        jLast_d = jLast_q;
        xLast_d = xLast_q;
        case (state_q)
            S_IDLE: begin
                if (startAccept) begin
                    state_d = S_RUN;
                    j_d     = '0;
                    x_d     = '0;
                    jLast_d = j_last;
                    xLast_d = x_last;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (atFinal) begin
                        state_d = S_DRAIN;
                        j_d     = '0;
                        x_d     = '0;
                    end else if (j_q == jLast_q) begin
                        j_d = '0;
                        x_d = x_q + X_SIZE'(1);
                    end else begin
                        j_d = j_q + J_SIZE'(1);
                    end
                end else if (abort) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drainsNext) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            x_q     <= '0;
            jLast_q <= '0;
            xLast_q <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            x_q     <= x_d;
            jLast_q <= jLast_d;
            xLast_q <= xLast_d;
        end
    end

    valid_delay_line #(
        .N(CALC_LATENCY)
    ) u_calc_stage (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (issue),
        .last_i  (atFinal),
        .valid_o (addr_valid),
        .last_o  (addr_last),
        .inner_o (calcInner)
    );

    valid_delay_line #(
        .N(READ_LATENCY)
    ) u_read_stage (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (addr_valid),
        .last_i  (addr_last),
        .valid_o (data_valid),
        .last_o  (data_last),
        .inner_o (readInner)
    );

    assign j     = j_q;
    assign x_enc = x_q;
    assign busy  = is_busy_state(state_q);
    assign done  = (state_q == S_DONE);

`ifdef BRAM_SCAN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (startAccept) begin
            stall_d = '0;
        end else if ((state_q == S_RUN) && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_bram_scan_sequencer.sv
// Directed self-checking bench for bram_scan_sequencer; outputs sampled on the falling edge.
module tb_bram_scan_sequencer;

    localparam int MAXC = 1200;
    localparam int CL   = 1;
    localparam int RL   = 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [8:0] j_last = '0;
    logic [2:0] x_last = '0;
    logic [8:0] j;
    logic [2:0] x_enc;
    logic       addr_valid, addr_last, data_valid, data_last, busy, done;
`ifdef BRAM_SCAN_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic       obsAv   [MAXC];
    logic       obsAl   [MAXC];
    logic       obsDv   [MAXC];
    logic       obsDl   [MAXC];
    logic       obsBusy [MAXC];
    logic [8:0] obsJ    [MAXC];
    logic [2:0] obsX    [MAXC];

    bram_scan_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .j_last     (j_last),
        .x_last     (x_last),
        .out_ready  (out_ready),
        .j          (j),
        .x_enc      (x_enc),
        .addr_valid (addr_valid),
        .addr_last  (addr_last),
        .data_valid (data_valid),
        .data_last  (data_last),
        .busy       (busy),
        .done       (done)
`ifdef BRAM_SCAN_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic doReset();
        start = 0; abort = 0; out_ready = 0; j_last = '0; x_last = '0;
        reset_n = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
    endtask

    // Cycle 0 is the first cycle after the accepted start; inputs set at negedge c apply to cycle c
    task automatic runSweep(input logic [8:0] jl, input logic [2:0] xl,
                            input int stallAt, input int stallLen, input int abortAt,
                            input int restartAt, input logic [8:0] jlRestart,
                            output int doneCyc);
        doneCyc = -1;
        @(negedge clock);
        j_last = jl; x_last = xl; start = 1; abort = 0; out_ready = 1;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clock);
            obsAv[c] = addr_valid; obsAl[c] = addr_last;
            obsDv[c] = data_valid; obsDl[c] = data_last;
            obsBusy[c] = busy; obsJ[c] = j; obsX[c] = x_enc;
            start = (c == restartAt);
            if (c == restartAt) j_last = jlRestart;
            abort = (c == abortAt);
            out_ready = !(c >= stallAt && c < stallAt + stallLen);
            if (done === 1'b1) begin
                doneCyc = c;
                break;
            end
        end
        start = 0; abort = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        reset_n = 0;
        #1;
        got = {j, x_enc, addr_valid, addr_last, data_valid, data_last, busy, done};
        checks++;
        if (got !== 18'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", got); end
        doReset();
        got = {j, x_enc, addr_valid, addr_last, data_valid, data_last, busy, done};
        checks++;
        if (got !== 18'd0) begin errors++; $display("FAIL post_reset_idle: got %h want 0", got); end
        start = 1; abort = 1; j_last = 9'd3; x_last = 3'd1;
        @(negedge clock);
        start = 0; abort = 0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_sweep();
        int dc, beat;
        doReset();
        runSweep(9'd3, 3'd1, -1, 0, -1, -1, 9'd0, dc);
        checks++;
        if (dc !== 10) begin errors++; $display("FAIL basic_done_cycle: got %0d want 10", dc); end
        for (int c = 0; c <= dc; c++) begin
            logic [4:0] got, want;
            got  = {obsAv[c], obsAl[c], obsDv[c], obsDl[c], obsBusy[c]};
            want = {c >= 1 && c <= 8, c == 8, c >= 2 && c <= 9, c == 9, c <= 9};
            checks++;
            if (got !== want) begin errors++; $display("FAIL basic_flags cycle %0d: got %b want %b", c, got, want); end
        end
        beat = 0;
        for (int c = 1; c <= dc; c++) begin
            if (obsAv[c] === 1'b1) begin
                checks++;
                if (obsJ[c-1] !== 9'(beat % 4) || obsX[c-1] !== 3'(beat / 4)) begin
                    errors++;
                    $display("FAIL basic_order beat %0d: got (%0d,%0d) want (%0d,%0d)", beat, obsJ[c-1], obsX[c-1], beat % 4, beat / 4);
                end
                beat++;
            end
        end
    endtask

    task automatic test_stall();
        int dc, beat;
        doReset();
        runSweep(9'd3, 3'd1, 2, 3, -1, -1, 9'd0, dc);
        checks++;
        if (dc !== 13) begin errors++; $display("FAIL stall_done_cycle: got %0d want 13", dc); end
        for (int c = 0; c <= dc; c++) begin
            logic [4:0] got, want;
            got  = {obsAv[c], obsAl[c], obsDv[c], obsDl[c], obsBusy[c]};
            want = {(c >= 1 && c <= 2) || (c >= 6 && c <= 11), c == 11,
                    (c >= 2 && c <= 3) || (c >= 7 && c <= 12), c == 12, c <= 12};
            checks++;
            if (got !== want) begin errors++; $display("FAIL stall_flags cycle %0d: got %b want %b", c, got, want); end
        end
        for (int c = 2; c <= 5; c++) begin
            checks++;
            if (obsJ[c] !== 9'd2 || obsX[c] !== 3'd0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got (%0d,%0d) want (2,0)", c, obsJ[c], obsX[c]);
            end
        end
        beat = 0;
        for (int c = 1; c <= dc; c++) begin
            if (obsAv[c] === 1'b1) begin
                checks++;
                if (obsJ[c-1] !== 9'(beat % 4) || obsX[c-1] !== 3'(beat / 4)) begin
                    errors++;
                    $display("FAIL stall_order beat %0d: got (%0d,%0d) want (%0d,%0d)", beat, obsJ[c-1], obsX[c-1], beat % 4, beat / 4);
                end
                beat++;
            end
        end
        checks++;
        if (beat !== 8) begin errors++; $display("FAIL stall_beats: got %0d want 8", beat); end
`ifdef BRAM_SCAN_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 16'd3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", stall_cycles); end
`endif
    endtask

    task automatic test_single_beat();
        int dc, busyCnt;
        doReset();
        runSweep(9'd0, 3'd0, -1, 0, -1, -1, 9'd0, dc);
        checks++;
        if (dc !== 3) begin errors++; $display("FAIL single_done_cycle: got %0d want 3", dc); end
        busyCnt = 0;
        for (int c = 0; c <= dc; c++) begin
            logic [3:0] got, want;
            got  = {obsAv[c], obsAl[c], obsDv[c], obsDl[c]};
            want = {c == 1, c == 1, c == 2, c == 2};
            if (obsBusy[c] === 1'b1) busyCnt++;
            checks++;
            if (got !== want) begin errors++; $display("FAIL single_flags cycle %0d: got %b want %b", c, got, want); end
        end
        // busy window counted from the start cycle up to the done cycle
        checks++;
        if (busyCnt + 1 !== 1 + CL + RL + 1) begin
            errors++;
            $display("FAIL single_busy_window: got %0d want %0d", busyCnt + 1, 1 + CL + RL + 1);
        end
    endtask

    task automatic test_abort();
        int dc, beats, lasts;
        doReset();
        runSweep(9'd3, 3'd1, -1, 0, 5, -1, 9'd0, dc);
        checks++;
        if (dc !== 7) begin errors++; $display("FAIL abort_done_cycle: got %0d want 7", dc); end
        for (int c = 0; c <= dc; c++) begin
            logic [4:0] got, want;
            got  = {obsAv[c], obsAl[c], obsDv[c], obsDl[c], obsBusy[c]};
            want = {c >= 1 && c <= 5, 1'b0, c >= 2 && c <= 6, 1'b0, c <= 6};
            checks++;
            if (got !== want) begin errors++; $display("FAIL abort_flags cycle %0d: got %b want %b", c, got, want); end
        end
        runSweep(9'd3, 3'd1, -1, 0, -1, -1, 9'd0, dc);
        beats = 0; lasts = 0;
        for (int c = 0; c <= dc; c++) begin
            if (obsAv[c] === 1'b1) beats++;
            if (obsAl[c] === 1'b1) lasts++;
        end
        checks++;
        if (dc !== 10 || beats !== 8 || lasts !== 1) begin
            errors++;
            $display("FAIL abort_restart: got done %0d beats %0d lasts %0d want 10 8 1", dc, beats, lasts);
        end
    endtask

    task automatic test_abort_final();
        int dc, lastAt;
        doReset();
        runSweep(9'd3, 3'd1, -1, 0, 7, -1, 9'd0, dc);
        lastAt = -1;
        for (int c = 0; c <= dc; c++) if (obsAl[c] === 1'b1) lastAt = c;
        checks++;
        if (dc !== 10 || lastAt !== 8) begin
            errors++;
            $display("FAIL abort_on_final: got done %0d last %0d want 10 8", dc, lastAt);
        end
        runSweep(9'd3, 3'd1, -1, 0, 8, -1, 9'd0, dc);
        lastAt = -1;
        for (int c = 0; c <= dc; c++) if (obsDl[c] === 1'b1) lastAt = c;
        checks++;
        if (dc !== 10 || lastAt !== 9) begin
            errors++;
            $display("FAIL abort_in_drain: got done %0d data_last %0d want 10 9", dc, lastAt);
        end
    endtask

    task automatic test_reset_midrun();
        logic [17:0] got;
        int dc, beats;
        doReset();
        j_last = 9'd3; x_last = 3'd1; out_ready = 1; start = 1;
        @(negedge clock);
        start = 0;
        repeat (3) @(negedge clock);
        #2;
        reset_n = 0;
        #1;
        got = {j, x_enc, addr_valid, addr_last, data_valid, data_last, busy, done};
        checks++;
        if (got !== 18'd0) begin errors++; $display("FAIL midrun_async_reset: got %h want 0", got); end
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrun_idle_after_reset: busy %b want 0", busy); end
        runSweep(9'd3, 3'd1, -1, 0, -1, -1, 9'd0, dc);
        beats = 0;
        for (int c = 0; c <= dc; c++) if (obsAv[c] === 1'b1) beats++;
        checks++;
        if (obsJ[0] !== 9'd0 || obsX[0] !== 3'd0 || beats !== 8 || dc !== 10) begin
            errors++;
            $display("FAIL midrun_fresh_sweep: got first (%0d,%0d) beats %0d done %0d want (0,0) 8 10", obsJ[0], obsX[0], beats, dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc, beats;
        doReset();
        runSweep(9'd3, 3'd1, -1, 0, -1, 3, 9'd1, dc);
        beats = 0;
        for (int c = 0; c <= dc; c++) if (obsAv[c] === 1'b1) beats++;
        checks++;
        if (beats !== 8 || dc !== 10 || obsAl[8] !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: got beats %0d done %0d last8 %b want 8 10 1", beats, dc, obsAl[8]);
        end
    endtask

    task automatic test_max_bound();
        int dc, beat, lastAt;
        doReset();
        runSweep(9'd511, 3'd1, -1, 0, -1, -1, 9'd0, dc);
        checks++;
        if (dc !== 1026) begin errors++; $display("FAIL max_done_cycle: got %0d want 1026", dc); end
        beat = 0; lastAt = -1;
        for (int c = 1; c <= dc; c++) begin
            if (obsAl[c] === 1'b1) lastAt = c;
            if (obsAv[c] === 1'b1) begin
                checks++;
                if (obsJ[c-1] !== 9'(beat % 512) || obsX[c-1] !== 3'(beat / 512)) begin
                    errors++;
                    $display("FAIL max_order beat %0d: got (%0d,%0d) want (%0d,%0d)", beat, obsJ[c-1], obsX[c-1], beat % 512, beat / 512);
                end
                beat++;
            end
        end
        checks++;
        if (beat !== 1024 || lastAt !== 1024) begin
            errors++;
            $display("FAIL max_beats: got %0d last at %0d want 1024 1024", beat, lastAt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_stall();
        test_single_beat();
        test_abort();
        test_abort_final();
        test_reset_midrun();
        test_back_to_back();
        test_max_bound();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
